fifo_read_ctrl: RTL

Read-side controller for the asynchronous grey-pointer FIFO. It runs entirely in the read clock domain and drains the dual-clock FIFO memory. It compares its own read pointer against the already-synchronized grey write pointer, issues memory reads, and absorbs the memory's one-cycle registered read latency in a two-entry output stage. Data leaves on a valid/ready stream with full throughput under backpressure. Its grey read pointer goes back to the write side for synchronization.

---
 rtl/fifo_read_ctrl_if.sv | 25 ++
 rtl/fifo_read_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl_if.sv
// Memory-read and output-stream signals of the grey-pointer FIFO read controller.
// master: controller side; slave: memory model and downstream consumer.
interface fifo_read_ctrl_if #(
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned FIFO_DEPTH  = 8
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW-1:0]          read_address;
    logic                   read_enable;
    logic [DATA_LENGTH-1:0] mem_data;
    logic [DATA_LENGTH-1:0] dataOut;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output read_address, read_enable, dataOut, out_valid,
        input  mem_data, out_ready
    );

    modport slave (
        input  read_address, read_enable, dataOut, out_valid,
        output mem_data, out_ready
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async grey-pointer FIFO with a two-entry output stage.
// Optional FIFO_READ_LEVEL_EN adds the read_level occupancy output.
module fifo_read_ctrl #(
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          read_clk,
    input  logic                          reset,
    input  logic [$clog2(FIFO_DEPTH):0]   write_ptr_grey,
    fifo_read_ctrl_if.master              bus,
    output logic [$clog2(FIFO_DEPTH):0]   read_ptr_grey,
    output logic                          empty
`ifdef FIFO_READ_LEVEL_EN
    ,
    output logic [$clog2(FIFO_DEPTH)+1:0] read_level
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0]            rd_bin_q, rd_bin_d;
    logic [AW:0]            rd_grey_q;
    logic [AW:0]            wr_bin;
    logic                   inflight_q, inflight_d;
    logic [1:0]             occ_q, occ_d;
    logic [DATA_LENGTH-1:0] head_q, head_d;
    logic [DATA_LENGTH-1:0] skid_q, skid_d;
    logic                   mem_empty;
    logic                   pop;
    logic                   read_enable;
    logic [2:0]             committed;

    // Each binary bit is the XOR of all grey bits at or above it.
    always_comb begin
        wr_bin = '0;
        for (int i = 0; i <= int'(AW); i++) begin
            wr_bin[i] = ^(write_ptr_grey >> i);
        end
    end

    assign mem_empty   = (rd_bin_q == wr_bin);
    assign pop         = (occ_q != 2'd0) & bus.out_ready;
    // Words already owed to the stage after this cycle's pop; keep it below two.
    assign committed   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign read_enable = !reset & !mem_empty & (committed < 3'd2);

    always_comb begin
        rd_bin_d   = rd_bin_q + {{AW{1'b0}}, read_enable};
        inflight_d = read_enable;
        occ_d      = occ_q;
        head_d     = head_q;
        skid_d     = skid_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = bus.mem_data;
                    occ_d  = 2'd1;
                end else begin
                    skid_d = bus.mem_data;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                // Head is left untouched when the stage drains so dataOut holds.
                if (occ_q == 2'd2) begin
                    head_d = skid_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    head_d = skid_q;
                    skid_d = bus.mem_data;
                end else begin
                    head_d = bus.mem_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge read_clk) begin
        if (reset) begin
            rd_bin_q   <= '0;
            rd_grey_q  <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            rd_bin_q   <= rd_bin_d;
            rd_grey_q  <= rd_bin_d ^ (rd_bin_d >> 1);
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    assign bus.read_address = rd_bin_q[AW-1:0];
    assign bus.read_enable  = read_enable;
    assign bus.dataOut      = head_q;
    assign bus.out_valid    = (occ_q != 2'd0);
    assign read_ptr_grey    = rd_grey_q;
    assign empty            = mem_empty & !inflight_q & (occ_q == 2'd0);

`ifdef FIFO_READ_LEVEL_EN
    assign read_level = {1'b0, wr_bin - rd_bin_q} + {{(AW + 1){1'b0}}, inflight_q}
                      + {{AW{1'b0}}, occ_q};
`endif
endmodule
